priority_encoder_serializer: RTL and testbench
==============================================

// Module: priority_encoder_serializer
// PURPOSE
//  Parametrised, registered successor to the 8x3 one-hot encoder. Captures a
//  WIDTH-bit request vector, then emits the index of every set bit, one per
//  handshake, lowest index first. Multi-hot and all-zero inputs are legal.
//  Sits between request/flag registers and a consumer that services one index per cycle.
// PARAMETERS
//  WIDTH   8                 request vector width (>=2)
//  CODE_W  $clog2(WIDTH)     code width; localparam derived from WIDTH, not overridable
// PORTS
//  clk    in   1       rising-edge clock
//  rst    in   1       asynchronous, active-high reset
//  load   in   1       capture data; honoured only when busy==0
//  data   in   WIDTH   request vector
//  busy   out  1       1 while pending bits remain (state EMIT)
//  valid  out  1       code is valid
//  ready  in   1       consumer accepts code when valid&&ready
//  code   out  CODE_W  index of the current bit; 0 when valid==0
//  done   out  1       one-cycle pulse: vector fully drained, or empty load
//  none   out  1       one-cycle pulse: load with data==0
// BEHAVIOUR
//  - Reset (async, any cycle): pend=0, state=IDLE; busy=valid=done=none=0, code=0.
//    Mid-stream reset discards all pending bits; no done pulse.
//  - State IDLE: busy=0, valid=0.
//    load=1, data!=0: pend<=data, go to EMIT.
//    load=1, data==0: stay IDLE; done=1 and none=1 for exactly the next cycle.
//  - State EMIT: busy=1, valid=1. code = lowest set index of pend (combinational from pend register).
//    valid&&ready: clear that bit in pend.
//      If it was the last set bit: go to IDLE; done=1 next cycle.
//    ready=0: pend, code and valid are held stable (no drop, no change).
//    load in EMIT is ignored; data is not sampled.
//  - Latency: load at edge t -> valid=1 with first code after edge t.
//    Throughput: with ready=1, K set bits drain in K cycles. Done follows the last handshake by one cycle.
//  - Back-to-back: load may assert in the same cycle done=1 (state is IDLE).
//  - done and none are registered outputs. valid and busy are decoded from the state register.
// CONFIGURATION
//  PENC_MSB_FIRST_EN defined: code is the highest set index of pend; bits drain from MSB down.
//  Undefined (default): lowest set index first, as above.
//  No other behaviour changes.
// TESTING
//  1. Walking one, WIDTH=8: for k=0..7, load 1<<k with ready=1.
//     Expect code=k and valid for 1 cycle, then done pulse, busy=0.
//  2. load 8'b1010_0110 with ready=1.
//     Expect codes 1,2,5,7 on consecutive cycles, then done. With MSB_FIRST_EN: 7,5,2,1.
//  3. Backpressure: load 8'b0001_1000, ready=0 for 3 cycles.
//     Expect code=3 held with valid=1. Then ready=1: codes 3,4, then done.
//  4. load 8'h00: valid never 1. done=1 and none=1 for one cycle; busy stays 0.
//  5. load 8'hFF, accept 2 codes, then assert rst async between edges.
//     Expect valid/busy=0 immediately and no done.
//     After release, load 8'h80: expect code=7.
//  6. While busy on 8'h03, pulse load with 8'h10: it is ignored (codes 0,1 only).
//     Load 8'h10 in the done cycle: expect code=4 next cycle.
//     Repeat scenarios 1-2 with WIDTH=16 (codes 0..15).

Source files
------------

// File: rtl/priority_encoder_serializer.sv
// Captures a WIDTH-bit request vector and emits the index of each set bit, one per
// valid/ready handshake. Optional macro PENC_MSB_FIRST_EN drains from the MSB down.
module priority_encoder_serializer #(
    parameter  int WIDTH  = 8,
    localparam int CODE_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  data,
    output logic              busy,
    output logic              valid,
    input  logic              ready,
    output logic [CODE_W-1:0] code,
    output logic              done,
    output logic              none
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   pend_r;
    logic [WIDTH-1:0]   pend_s;
    logic               done_r;
    logic               done_s;
    logic               none_r;
    logic               none_s;
    logic [CODE_W-1:0]  sel_s;

    // Index of the bit to serve next; the scan direction sets the drain order.
    function automatic logic [CODE_W-1:0] pick_index(input logic [WIDTH-1:0] vec);
        logic [CODE_W-1:0] idx;
        idx = {CODE_W{1'b0}};
`ifdef PENC_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
`endif
        return idx;
    endfunction

    // Vector with the bit at position idx cleared.
    function automatic logic [WIDTH-1:0] clear_index(input logic [WIDTH-1:0] vec,
                                                     input logic [CODE_W-1:0] idx);
        logic [WIDTH-1:0] res;
        res = vec;
        for (int i = 0; i < WIDTH; i++) begin
            if (CODE_W'(i) == idx) begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

    assign sel_s = pick_index(pend_r);

    // Next-state, pending-vector update and pulse generation.
    always_comb begin
        state_s = state_r;
        pend_s  = pend_r;
        done_s  = 1'b0;
        none_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (load) begin
                    if (data != {WIDTH{1'b0}}) begin
                        pend_s  = data;
                        state_s = EMIT;
                    end else begin
                        done_s = 1'b1;
                        none_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EMIT: begin
                // load is deliberately not looked at here: a busy serializer ignores it.
                if (ready) begin
                    pend_s = clear_index(pend_r, sel_s);
                    if (pend_s == {WIDTH{1'b0}}) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = EMIT;
                    end
                end else begin
                    pend_s = pend_r;
                end
            end
            default: begin
                state_s = IDLE;
                pend_s  = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, pending bits and the registered done/none pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            pend_r  <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
            none_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pend_r  <= pend_s;
            done_r  <= done_s;
            none_r  <= none_s;
        end
    end

    // Handshake outputs are decoded straight from the state register.
    always_comb begin
        busy  = (state_r == EMIT);
        valid = (state_r == EMIT);
        if (state_r == EMIT) begin
            code = sel_s;
        end else begin
            code = {CODE_W{1'b0}};
        end
    end

    assign done = done_r;
    assign none = none_r;

endmodule

// File: tb/tb_priority_encoder_serializer.sv
// Scoreboard bench for priority_encoder_serializer: an 8-bit and a 16-bit instance,
// expected codes queued when a load is seen and popped on each handshake.
module tb_priority_encoder_serializer;

    logic        clk;
    logic        rst;
    logic        load8;
    logic [7:0]  data8;
    logic        ready8;
    logic        busy8;
    logic        valid8;
    logic [2:0]  code8;
    logic        done8;
    logic        none8;
    logic        load16;
    logic [15:0] data16;
    logic        ready16;
    logic        busy16;
    logic        valid16;
    logic [3:0]  code16;
    logic        done16;
    logic        none16;

    int checks = 0;
    int errors = 0;

    int exp_q [2][$];
    bit model_busy [2];
    bit exp_done [2];
    bit exp_none [2];

    priority_encoder_serializer #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .load  (load8),
        .data  (data8),
        .busy  (busy8),
        .valid (valid8),
        .ready (ready8),
        .code  (code8),
        .done  (done8),
        .none  (none8)
    );

    priority_encoder_serializer #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .load  (load16),
        .data  (data16),
        .busy  (busy16),
        .valid (valid16),
        .ready (ready16),
        .code  (code16),
        .done  (done16),
        .none  (none16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference: per-cycle compare at the falling edge, then advance the model.
    always @(negedge clk) begin
        int       w;
        int       obs_code;
        int       exp_code;
        logic     v, b, dn, nn, ld, rd;
        logic [15:0] d;
        bit       nd, nz;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                w = 8; obs_code = int'(code8); v = valid8; b = busy8; dn = done8; nn = none8;
                ld = load8; rd = ready8; d = {8'h00, data8};
            end else begin
                w = 16; obs_code = int'(code16); v = valid16; b = busy16; dn = done16; nn = none16;
                ld = load16; rd = ready16; d = data16;
            end
            if (rst) begin
                check_value($sformatf("w%0d_rst_busy", w), int'(b), 0);
                check_value($sformatf("w%0d_rst_valid", w), int'(v), 0);
                check_value($sformatf("w%0d_rst_code", w), obs_code, 0);
                check_value($sformatf("w%0d_rst_done", w), int'(dn), 0);
                check_value($sformatf("w%0d_rst_none", w), int'(nn), 0);
                exp_q[k].delete();
                model_busy[k] = 1'b0;
                exp_done[k]   = 1'b0;
                exp_none[k]   = 1'b0;
            end else begin
                exp_code = model_busy[k] ? exp_q[k][0] : 0;
                check_value($sformatf("w%0d_busy", w), int'(b), int'(model_busy[k]));
                check_value($sformatf("w%0d_valid", w), int'(v), int'(model_busy[k]));
                check_value($sformatf("w%0d_code", w), obs_code, exp_code);
                check_value($sformatf("w%0d_done", w), int'(dn), int'(exp_done[k]));
                check_value($sformatf("w%0d_none", w), int'(nn), int'(exp_none[k]));
                nd = 1'b0;
                nz = 1'b0;
                if (model_busy[k]) begin
                    if (rd) begin
                        void'(exp_q[k].pop_front());
                        if (exp_q[k].size() == 0) begin
                            model_busy[k] = 1'b0;
                            nd = 1'b1;
                        end
                    end
                end else if (ld) begin
                    if (d == 16'h0000) begin
                        nd = 1'b1;
                        nz = 1'b1;
                    end else begin
`ifdef PENC_MSB_FIRST_EN
                        for (int i = w - 1; i >= 0; i--) if (d[i]) exp_q[k].push_back(i);
`else
                        for (int i = 0; i < w; i++) if (d[i]) exp_q[k].push_back(i);
`endif
                        model_busy[k] = 1'b1;
                    end
                end
                exp_done[k] = nd;
                exp_none[k] = nz;
            end
        end
    end

    task automatic set_load(input int k, input logic l, input logic [15:0] d);
        if (k == 0) begin
            load8 = l;
            data8 = d[7:0];
        end else begin
            load16 = l;
            data16 = d;
        end
    endtask

    task automatic do_load(input int k, input logic [15:0] d);
        @(posedge clk); #1;
        set_load(k, 1'b1, d);
        @(posedge clk); #1;
        set_load(k, 1'b0, 16'($urandom));
    endtask

    task automatic wait_drain(input int k);
        int timed_out;
        timed_out = 1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #2;
            if (!model_busy[k] && !exp_done[k] && !exp_none[k]) begin
                timed_out = 0;
                break;
            end
        end
        check_value($sformatf("drain_timeout_%0d", k), timed_out, 0);
    endtask

    initial begin
        rst = 1'b1;
        load8 = 1'b0; data8 = 8'h00; ready8 = 1'b1;
        load16 = 1'b0; data16 = 16'h0000; ready16 = 1'b1;
        #1;
        check_value("reset_valid", int'(valid8), 0);
        check_value("reset_busy", int'(busy8), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Walking one and a multi-hot pattern on both widths.
        for (int b = 0; b < 8; b++) begin
            do_load(0, 16'(1) << b);
            wait_drain(0);
        end
        do_load(0, 16'h00A6);
        wait_drain(0);
        for (int b = 0; b < 16; b++) begin
            do_load(1, 16'(1) << b);
            wait_drain(1);
        end
        do_load(1, 16'hA0A6);
        wait_drain(1);

        // Backpressure holds the current code.
        ready8 = 1'b0;
        do_load(0, 16'h0018);
        repeat (3) @(posedge clk);
        #1 ready8 = 1'b1;
        wait_drain(0);

        // Empty load.
        do_load(0, 16'h0000);
        wait_drain(0);

        // Asynchronous reset mid-stream, then reload.
        do_load(0, 16'h00FF);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_value("async_rst_valid", int'(valid8), 0);
        check_value("async_rst_busy", int'(busy8), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_load(0, 16'h0080);
        wait_drain(0);

        // Load while busy is ignored; load in the done cycle is taken.
        do_load(0, 16'h0003);
        set_load(0, 1'b1, 16'h0010);
        @(posedge clk); #1;
        set_load(0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        set_load(0, 1'b1, 16'h0010);
        @(posedge clk); #1;
        set_load(0, 1'b0, 16'h0000);
        wait_drain(0);

        // Random vectors with random backpressure on the wide instance.
        for (int t = 0; t < 6; t++) begin
            ready16 = 1'($urandom);
            do_load(1, 16'($urandom));
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                ready16 = 1'($urandom);
            end
            ready16 = 1'b1;
            wait_drain(1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
